// File: rtl/riscv_fetch.sv
// riscv_fetch: sequential PC fetch, one outstanding icache read, 2-entry out FIFO.
// Ports: clk/rst_n, branch_*, icache_* request/response, fetch_* to decode, squash_out.
module riscv_fetch #(
  parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_request,
  input  logic [31:0] branch_pc,
  output logic        icache_rd,
  output logic [31:0] icache_pc,
  input  logic        icache_accept,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  input  logic        icache_error,
  input  logic        icache_page_fault,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault_fetch,
  output logic        fetch_fault_page,
  input  logic        fetch_accept,
  output logic        squash_out
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ferr;
    logic        fpf;
  } ent_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic        discard;
  ent_t        fifo [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        flush;
  logic        fault;
  logic        push;
  logic        pop;
  logic        accepted;
  logic [2:0]  count_after;
  ent_t        head;

  assign flush = branch_request && (state != BOOT);
  assign fault = icache_error || icache_page_fault;
  assign push  = icache_valid && !discard && !flush;
  assign pop   = (count != 2'd0) && fetch_accept && !flush;

  assign count_after = {1'b0, count} + {2'b00, push}
                     - {2'b00, pop};

  // A faulting push stops issue in the same cycle so
  // nothing is in flight once HALT is entered.
  assign icache_rd = (state == RUN) && !branch_request
                   && (!outstanding || icache_valid)
                   && (count_after < 3'd2)
                   && !(push && fault);

  assign icache_pc  = pc;
  assign accepted   = icache_rd && icache_accept;
  assign squash_out = flush;

  assign head              = fifo[rd_ptr];
  assign fetch_valid       = (count != 2'd0);
  assign fetch_pc          = head.pc;
  assign fetch_instr       = head.instr;
  assign fetch_fault_fetch = head.ferr;
  assign fetch_fault_page  = head.fpf;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= BOOT;
      pc          <= BOOT_VECTOR;
      req_pc      <= BOOT_VECTOR;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo[0]     <= '{BOOT_VECTOR, 32'd0, 1'b0, 1'b0};
      fifo[1]     <= '{BOOT_VECTOR, 32'd0, 1'b0, 1'b0};
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN:  if (push && fault) state <= HALT;
        HALT: if (flush) state <= RUN;
        default: state <= BOOT;
      endcase

      if (icache_valid) outstanding <= 1'b0;
      if (accepted) begin
        outstanding <= 1'b1;
        pc          <= pc + 32'd4;
        req_pc      <= pc;
      end

      // Only a request still in flight after the branch
      // cycle can come back stale.
      if (flush) begin
        discard <= outstanding && !icache_valid;
        pc      <= {branch_pc[31:2], 2'b00};
      end else if (icache_valid) begin
        discard <= 1'b0;
      end

      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{req_pc, icache_inst,
                           icache_error, icache_page_fault};
        end
        wr_ptr <= wr_ptr ^ push;
        rd_ptr <= rd_ptr ^ pop;
        count  <= count_after[1:0];
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: icache model plus scoreboard of expected decode entries.
// Ports: none; drives riscv_fetch with BOOT_VECTOR 0x100.
module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_request;
  logic [31:0] branch_pc;
  logic        icache_rd;
  logic [31:0] icache_pc;
  logic        icache_accept;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        icache_error;
  logic        icache_page_fault;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_fault_fetch;
  logic        fetch_fault_page;
  logic        fetch_accept;
  logic        squash_out;

  riscv_fetch #(.BOOT_VECTOR(32'h0000_0100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .branch_request(branch_request),
    .branch_pc(branch_pc),
    .icache_rd(icache_rd),
    .icache_pc(icache_pc),
    .icache_accept(icache_accept),
    .icache_valid(icache_valid),
    .icache_inst(icache_inst),
    .icache_error(icache_error),
    .icache_page_fault(icache_page_fault),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc),
    .fetch_fault_fetch(fetch_fault_fetch),
    .fetch_fault_page(fetch_fault_page),
    .fetch_accept(fetch_accept),
    .squash_out(squash_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cd;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    logic        pf;
  } ent_t;

  req_t pend[$];
  ent_t sb[$];

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int pops = 0;
  int pf_pops = 0;
  int halt_rd = 0;
  int first_rd_cyc;
  int stale_cyc;
  int lat = 1;
  bit lat_rand = 0;
  bit acc_rand = 0;
  bit ic_rand = 0;
  bit acc_on = 1;
  bit br_drive = 0;
  bit halted = 0;
  bit track_rd = 0;
  bit track_pop = 0;
  bit saw_zero = 0;
  logic [31:0] br_target = '0;
  logic [31:0] exp_req_pc;
  logic [31:0] last_req = '0;
  logic [31:0] first_pop_pc = '0;
  logic [31:0] pf_pop_pc = '0;
  logic [31:0] fault_pc = 32'h1;
  logic [31:0] err_pc = 32'h1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    req_t r;
    ent_t e;
    bit   resp;
    bit   brk;
    int   l;
    @(posedge clk);
    #1;
    cyc++;
    brk = br_drive;
    branch_request = br_drive;
    branch_pc = br_target;
    fetch_accept = acc_rand ? ($urandom_range(3) != 0) : acc_on;
    icache_accept = ic_rand ? ($urandom_range(3) != 0) : 1'b1;
    icache_valid = 1'b0;
    icache_inst = '0;
    icache_error = 1'b0;
    icache_page_fault = 1'b0;
    resp = 0;
    r = '{32'd0, 0, 1'b0};
    if (pend.size() != 0) begin
      if (pend[0].cd == 0) begin
        r = pend.pop_front();
        resp = 1;
        icache_valid = 1'b1;
        icache_inst = instr_of(r.pc);
        icache_page_fault = (r.pc == fault_pc);
        icache_error = (r.pc == err_pc);
      end else begin
        pend[0].cd = pend[0].cd - 1;
      end
    end
    if (resp && !r.stale && !brk
        && (icache_error || icache_page_fault))
      halted = 1;
    #1;
    chk("squash", {31'd0, squash_out}, {31'd0, brk});
    chk("valid_vs_model", {31'd0, fetch_valid},
        {31'd0, sb.size() != 0});
    if (brk) chk("rd_in_branch", {31'd0, icache_rd}, 0);
    if (sb.size() == 2 && !fetch_accept)
      chk("rd_full", {31'd0, icache_rd}, 0);
    if (fetch_valid && fetch_accept && !brk) begin
      if (sb.size() == 0) begin
        chk("pop_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("fetch_pc", fetch_pc, e.pc);
        chk("fetch_instr", fetch_instr, e.instr);
        chk("fault_fetch", {31'd0, fetch_fault_fetch}, {31'd0, e.err});
        chk("fault_page", {31'd0, fetch_fault_page}, {31'd0, e.pf});
        pops++;
        if (fetch_fault_page) begin
          pf_pops++;
          pf_pop_pc = fetch_pc;
        end
        if (track_pop) begin
          first_pop_pc = fetch_pc;
          track_pop = 0;
        end
      end
    end
    if (icache_rd && icache_accept) begin
      chk("req_pc", icache_pc, exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
      last_req = icache_pc;
      l = lat_rand ? $urandom_range(2) : lat - 1;
      pend.push_back('{icache_pc, l, 1'b0});
      if (halted) halt_rd++;
      if (icache_pc == 32'd0) saw_zero = 1;
      if (track_rd) begin
        first_rd_cyc = cyc;
        track_rd = 0;
      end
    end
    if (resp && r.stale) stale_cyc = cyc;
    if (brk) begin
      sb.delete();
      foreach (pend[i]) pend[i].stale = 1;
      exp_req_pc = {br_target[31:2], 2'b00};
      halted = 0;
      track_rd = 1;
      track_pop = 1;
    end else if (resp && !r.stale) begin
      sb.push_back('{r.pc, instr_of(r.pc),
                     icache_error, icache_page_fault});
    end
  endtask

  task automatic branch_to(input logic [31:0] t);
    br_drive = 1;
    br_target = t;
    step();
    br_drive = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    branch_request = 1'b0;
    branch_pc = '0;
    icache_accept = 1'b1;
    icache_valid = 1'b0;
    icache_inst = '0;
    icache_error = 1'b0;
    icache_page_fault = 1'b0;
    fetch_accept = 1'b1;
    exp_req_pc = 32'h100;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", {31'd0, icache_rd}, 0);
    chk("rst_valid", {31'd0, fetch_valid}, 0);
    chk("rst_pc", fetch_pc, 32'h100);
    chk("rst_instr", fetch_instr, 0);
    chk("rst_faults", {30'd0, fetch_fault_fetch, fetch_fault_page}, 0);
    chk("rst_squash", {31'd0, squash_out}, 0);

    // BOOT cycle: a branch here must be ignored
    rst_n = 1'b0;
    branch_request = 1'b1;
    branch_pc = 32'h5000;
    #1;
    chk("boot_squash", {31'd0, squash_out}, 0);
    chk("boot_rd", {31'd0, icache_rd}, 0);

    step();
    chk("first_rd", {31'd0, icache_rd}, 1);
    chk("first_pc", last_req, 32'h100);
    repeat (9) step();
    pops = 0;
    repeat (20) step();
    chk("throughput", pops, 20);

    acc_on = 0;
    repeat (5) step();
    acc_on = 1;
    repeat (10) step();

    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() != 0 && pend[0].cd == 2 && !pend[0].stale) break;
      step();
    end
    if (!(pend.size() != 0 && pend[0].cd == 2))
      chk("timeout_outstanding", 0, 1);
    first_rd_cyc = -1;
    stale_cyc = -2;
    branch_to(32'h2002);
    repeat (12) step();
    chk("rd_at_stale_return", first_rd_cyc, stale_cyc);
    chk("first_pop_after_br", first_pop_pc, 32'h2000);

    lat = 1;
    repeat (3) step();
    for (int i = 0; i < 20; i++) begin
      if (pend.size() != 0 && pend[0].cd == 0 && !pend[0].stale) break;
      step();
    end
    if (!(pend.size() != 0 && pend[0].cd == 0))
      chk("timeout_resp", 0, 1);
    branch_to(32'h3000);
    step();
    chk("rd_after_same_cycle_br", {31'd0, icache_rd}, 1);
    chk("pc_after_same_cycle_br", last_req, 32'h3000);
    repeat (5) step();

    fault_pc = 32'h40;
    halt_rd = 0;
    pf_pops = 0;
    branch_to(32'h30);
    for (int i = 0; i < 30 && !halted; i++) step();
    if (!halted) chk("timeout_fault", 0, 1);
    repeat (10) step();
    chk("halt_no_rd", halt_rd, 0);
    chk("fault_pops", pf_pops, 1);
    chk("fault_pop_pc", pf_pop_pc, 32'h40);
    pops = 0;
    branch_to(32'h80);
    repeat (10) step();
    chk("resume_after_halt", {31'd0, pops != 0}, 1);
    fault_pc = 32'h1;

    saw_zero = 0;
    branch_to(32'hFFFF_FFF4);
    repeat (10) step();
    chk("pc_wrap", {31'd0, saw_zero}, 1);

    err_pc = 32'h0000_0A00;
    acc_rand = 1;
    ic_rand = 1;
    lat_rand = 1;
    halt_rd = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(24) == 0)
        branch_to($urandom_range(32'h0C00));
      else
        step();
    end
    chk("rand_halt_no_rd", halt_rd, 0);
    acc_rand = 0;
    ic_rand = 0;
    lat_rand = 0;
    err_pc = 32'h1;
    branch_to(32'h400);
    repeat (10) step();

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    branch_request = 1'b0;
    icache_valid = 1'b0;
    pend.delete();
    sb.delete();
    halted = 0;
    #1;
    chk("midrst_valid", {31'd0, fetch_valid}, 0);
    chk("midrst_rd", {31'd0, icache_rd}, 0);
    chk("midrst_pc", fetch_pc, 32'h100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_req_pc = 32'h100;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch stage that drives the decode stage's fetch interface. It generates sequential PCs and issues single-outstanding read requests to the instruction cache. Returned instructions and their fault flags are buffered in a 2-entry output FIFO and presented with a valid/accept handshake. On a branch redirect it squashes downstream state and discards stale responses, and it halts after delivering a faulting fetch until the next redirect.

## Interface
- BOOT_VECTOR, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- branch_request  in  1  redirect fetch this cycle.
- branch_pc  in  32  redirect target; bits [1:0] treated as 0.
- icache_rd  out  1  read request.
- icache_pc  out  32  request address; always word aligned.
- icache_accept  in  1  request taken when icache_rd && icache_accept.
- icache_valid  in  1  response valid, at most one per accepted request, any cycle after acceptance.
- icache_inst  in  32  response instruction word.
- icache_error  in  1  bus fault qualifying the response.
- icache_page_fault  in  1  page fault qualifying the response.
- fetch_valid  out  1  decode-side entry valid.
- fetch_instr  out  32  instruction, passed unmodified, faults included.
- fetch_pc  out  32  PC of the entry.
- fetch_fault_fetch  out  1  entry carries bus fault.
- fetch_fault_page  out  1  entry carries page fault.
- fetch_accept  in  1  decode consumes the entry when fetch_valid && fetch_accept.
- squash_out  out  1  flush for the decode buffer.

## Operation
- State machine states:
  - BOOT (reset state) moves to RUN on the first clock edge.
  - RUN moves to HALT when a faulting response is pushed.
  - HALT moves to RUN on branch_request.
  - branch_request in BOOT is ignored.
- Registers:
  - pc (reset BOOT_VECTOR);
  - outstanding flag;
  - discard flag;
  - 2-entry FIFO of {pc, instr, fault_fetch, fault_page} with a 2-bit count.
- Issue rule: icache_rd = (state==RUN) && !branch_request && (!outstanding || icache_valid) && (count_after + 1 <= 2).
  - count_after is the FIFO count after this cycle's push/pop.
  - A request returning this cycle frees its outstanding slot.
- icache_pc = pc. On an accepted request, pc <= pc + 4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0) and outstanding <= 1.
- Response handling (icache_valid):
  - outstanding clears.
  - If discard=1: the response is dropped and discard clears.
  - Otherwise the response is pushed with its request PC, tracked in a req_pc register.
- Fault: if icache_error or icache_page_fault is set on a pushed response, the flags are stored and state goes to HALT. No further requests are issued.
- Branch (highest priority), when branch_request is set in RUN or HALT:
  - FIFO is emptied.
  - pc <= {branch_pc[31:2],2'b00}.
  - state <= RUN.
  - icache_rd is forced 0 this cycle.
  - If a request is outstanding and no response arrives this cycle, discard <= 1.
  - A response arriving in the same cycle is dropped.
  - squash_out = branch_request && state!=BOOT (combinational).
- Pop and push in the same cycle with count=2 is legal; the count stays 2.
- No push is ever attempted when full; the issue rule guarantees this.

## Timing
- Reset values:
  - icache_rd 0, fetch_valid 0, fetch_pc BOOT_VECTOR, fetch_instr 0;
  - both fault outputs 0, squash_out 0;
  - count 0, outstanding 0, discard 0, state BOOT.
- The first icache_rd is in the cycle after the first clock edge following reset release.
- FIFO outputs are registered: icache_valid in cycle N gives fetch_valid in N+1 when the FIFO was empty.
- With icache_accept and icache_valid always high one cycle after the request, and fetch_accept high: one instruction per cycle sustained, PC stepping by 4.
- fetch_valid/fetch_* hold stable while fetch_valid && !fetch_accept.
- Branch in cycle N: fetch_valid=0 in N+1. The request to branch_pc is issued in N+1 if no discard is pending, otherwise in the cycle the stale response returns.
- Asserting reset mid-operation clears all state immediately. A response arriving later from a pre-reset request is not protected against; the icache must be reset together with this block.

## Test plan
- Reset release, BOOT_VECTOR=0x100, icache always-ready with 1-cycle response -> requests at 0x100, 0x104, 0x108…; fetch_valid from the 3rd cycle; one entry per cycle.
- fetch_accept=0 for 5 cycles -> at most 2 entries buffered, icache_rd low while full, no loss or duplicates after release.
- Branch to 0x2002 while a request is outstanding with a 3-cycle response -> squash_out pulses one cycle, the stale response is dropped, the next request is 0x2000, and the first entry has fetch_pc=0x2000.
- Branch in the same cycle as icache_valid -> the response is dropped, discard is not set, and the next request goes to the target in the following cycle.
- icache_page_fault on the response for 0x40 -> the entry has fault_page=1 and pc 0x40, no further icache_rd; a branch to 0x80 resumes fetch.
- pc=0xFFFF_FFFC -> next request 0x0000_0000.
